// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: size codes, FSM states, data width.
// Latency: n/a. Backpressure: n/a.
package data_mem_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_byte_array.sv
// Byte storage, MEM_BYTES x 8, big-endian 4-lane view starting at addr (lane 0 = mem[addr]).
// Latency: combinational read, write on rising edge. Backpressure: none; lanes past the end are dropped.
module mem_byte_array #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];
  logic [AW:0] idx [4];
  logic        ok  [4];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = {1'b0, addr} + (AW+1)'(i);
      ok[i]  = idx[i] < (AW+1)'(MEM_BYTES);
      rdata[31-8*i -: 8] = ok[i] ? mem[idx[i][AW-1:0]] : 8'h00;
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i] && ok[i]) mem[idx[i][AW-1:0]] <= wdata[31-8*i -: 8];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Big-endian byte/half/word data memory with valid/ready handshake; MEM_ALIGN_CHECK_EN flags misalignment.
// Latency: accept edge to resp_valid is WAIT_CYCLES+1 edges. Backpressure: holds response until resp_ready.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              cap_write, cap_signed;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              cur_write, cur_signed;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              accept, enter_resp, range_err, align_err, acc_err;
  logic [ADDR_W:0]   end_addr;
  logic [AW-1:0]     eff_addr;
  logic [3:0]        lanes, mem_we;
  logic [31:0]       wlane, rd, ld_data;

  assign accept     = req_valid & req_ready;
  assign enter_resp = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == '0));

  // With zero wait states the access happens on the accept edge, so it must see the live request.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_write = req_write; cur_size = req_size; cur_signed = req_signed;
      cur_addr  = req_addr;  cur_wdata = req_wdata;
    end else begin
      cur_write = cap_write; cur_size = cap_size; cur_signed = cap_signed;
      cur_addr  = cap_addr;  cur_wdata = cap_wdata;
    end
  end

  assign end_addr  = {1'b0, cur_addr} + {{(ADDR_W-2){1'b0}}, size_bytes(cur_size)};
  assign range_err = end_addr > (ADDR_W+1)'(MEM_BYTES);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = ((cur_size == SIZE_HALF) && cur_addr[0]) ||
                     ((cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00));
  assign eff_addr  = cur_addr[AW-1:0];
`else
  assign align_err = 1'b0;
  always_comb begin
    eff_addr = cur_addr[AW-1:0];
    if (cur_size == SIZE_HALF) eff_addr[0] = 1'b0;
    if (cur_size == SIZE_WORD) eff_addr[1:0] = 2'b00;
  end
`endif

  assign acc_err = (cur_size == SIZE_RSVD) | range_err | align_err;

  always_comb begin
    lanes = 4'b0000;
    wlane = cur_wdata[31:0];
    ld_data = 32'h0;
    case (cur_size)
      SIZE_BYTE: begin
        lanes = 4'b0001;
        wlane = {cur_wdata[7:0], 24'h0};
        ld_data = {{24{cur_signed & rd[31]}}, rd[31:24]};
      end
      SIZE_HALF: begin
        lanes = 4'b0011;
        wlane = {cur_wdata[15:0], 16'h0};
        ld_data = {{16{cur_signed & rd[31]}}, rd[31:16]};
      end
      SIZE_WORD: begin
        lanes = 4'b1111;
        ld_data = rd;
      end
      default: ;
    endcase
    if (cur_write || acc_err) ld_data = 32'h0;
  end

  assign mem_we = (enter_resp && cur_write && !acc_err) ? lanes : 4'b0000;

  mem_byte_array #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_mem (
    .clk   (clk),
    .addr  (eff_addr),
    .we    (mem_we),
    .wdata (wlane),
    .rdata (rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_size   <= SIZE_BYTE;
      cap_signed <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          cap_write  <= req_write;
          cap_size   <= req_size;
          cap_signed <= req_signed;
          cap_addr   <= req_addr;
          cap_wdata  <= req_wdata;
          req_ready  <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= DATA_W'(ld_data);
            resp_err   <= acc_err;
          end else begin
            state <= ST_WAIT;
            cnt   <= CW'(WAIT_CYCLES - 1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= DATA_W'(ld_data);
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: if (resp_ready) begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: vector table, hand-written corner sequences, randomized traffic vs a byte-array model.
// Instance 1 uses WAIT_CYCLES=1, instance 0 uses WAIT_CYCLES=0.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2], req_ready [2], req_write [2], req_signed [2];
  logic        resp_valid [2], resp_ready [2], resp_err [2];
  logic [1:0]  req_size [2];
  logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];

  data_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(1024), .WAIT_CYCLES(1), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  data_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(1024), .WAIT_CYCLES(0), .DATA_W(32)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mm [1024];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vt [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference: a flat byte array, big-endian, range and alignment rules in plain arithmetic.
  task automatic model_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
    int nb;
    longint ea;
    logic [31:0] v, t;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea = {32'h0, a};
    er = (sz == 2'd3) || (ea + nb > 1024);
`ifdef MEM_ALIGN_CHECK_EN
    if (ea % nb != 0) er = 1'b1;
`else
    ea = ea - (ea % nb);
`endif
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int k = 0; k < nb; k++) begin
          t = wd >> (8 * (nb - 1 - k));
          mm[int'(ea) + k] = t[7:0];
        end
      end else begin
        v = 32'h0;
        for (int k = 0; k < nb; k++) v = (v << 8) | {24'h0, mm[int'(ea) + k]};
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endtask

  task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    rd = 32'h0; er = 1'b0; lat = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin check("req_ready_timeout", {31'h0, req_ready[d]}, 32'h1); return; end
    req_write[d] = w; req_size[d] = sz; req_signed[d] = sg;
    req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom); req_size[d] = 2'($urandom); req_signed[d] = 1'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (resp_valid[d] !== 1'b1) begin check("resp_valid_timeout", {31'h0, resp_valid[d]}, 32'h1); return; end
    rd = resp_rdata[d];
    er = resp_err[d];
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, erd, wd, a;
    logic        er, eer, w, sg;
    logic [1:0]  sz;
    int          lat, n;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0; req_signed[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d req_ready", d), {31'h0, req_ready[d]}, 32'h1);
      check($sformatf("rst%0d resp_valid", d), {31'h0, resp_valid[d]}, 32'h0);
      check($sformatf("rst%0d resp_rdata", d), resp_rdata[d], 32'h0);
      check($sformatf("rst%0d resp_err", d), {31'h0, resp_err[d]}, 32'h0);
    end
    rst = 1'b1;

    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      model_req(1'b1, 2'd2, 1'b0, 32'(i * 4), wd, erd, eer);
      do_req(1, 1'b1, 2'd2, 1'b0, 32'(i * 4), wd, rd, er, lat);
      check($sformatf("init%0d err", i), {31'h0, er}, {31'h0, eer});
    end

    vt.push_back(mk(1, 2, 0, 32'h10, 32'h12345678, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h10, 32'h0, 32'h12345678, 0));
    vt.push_back(mk(0, 0, 0, 32'h10, 32'h0, 32'h00000012, 0));
    vt.push_back(mk(0, 0, 0, 32'h13, 32'h0, 32'h00000078, 0));
    vt.push_back(mk(1, 2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0));
    vt.push_back(mk(0, 0, 1, 32'h20, 32'h0, 32'hFFFFFF80, 0));
    vt.push_back(mk(0, 0, 0, 32'h21, 32'h0, 32'h000000FF, 0));
    vt.push_back(mk(0, 1, 1, 32'h22, 32'h0, 32'h00007F01, 0));
    vt.push_back(mk(0, 1, 1, 32'h20, 32'h0, 32'hFFFF80FF, 0));
    vt.push_back(mk(0, 1, 0, 32'h20, 32'h0, 32'h000080FF, 0));
    vt.push_back(mk(1, 0, 0, 32'h21, 32'h123456AB, 32'h0, 0));
    vt.push_back(mk(0, 2, 1, 32'h20, 32'h0, 32'h80AB7F01, 0));
    vt.push_back(mk(1, 1, 0, 32'h22, 32'h9999CDEF, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h20, 32'h0, 32'h80ABCDEF, 0));
    vt.push_back(mk(1, 2, 0, 32'h3FC, 32'hDEADBEEF, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h3FC, 32'h0, 32'hDEADBEEF, 0));
    vt.push_back(mk(1, 2, 0, 32'h3FE, 32'h01020304, 32'h0, 1));
    vt.push_back(mk(0, 2, 0, 32'h3FC, 32'h0, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 0, 0, 32'h400, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 0, 1, 32'h3FF, 32'h0, 32'hFFFFFFEF, 0));
    vt.push_back(mk(0, 3, 0, 32'h10, 32'h0, 32'h0, 1));
    vt.push_back(mk(1, 3, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1));
    vt.push_back(mk(0, 2, 0, 32'h10, 32'h0, 32'h12345678, 0));
    vt.push_back(mk(0, 2, 0, 32'h80000010, 32'h0, 32'h0, 1));
    vt.push_back(mk(1, 2, 0, 32'h40, 32'h11223344, 32'h0, 0));
`ifdef MEM_ALIGN_CHECK_EN
    vt.push_back(mk(0, 2, 0, 32'h42, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 1, 1, 32'h43, 32'h0, 32'h0, 1));
    vt.push_back(mk(1, 1, 0, 32'h41, 32'h00005566, 32'h0, 1));
    vt.push_back(mk(0, 2, 0, 32'h40, 32'h0, 32'h11223344, 0));
`else
    vt.push_back(mk(0, 2, 0, 32'h42, 32'h0, 32'h11223344, 0));
    vt.push_back(mk(0, 1, 1, 32'h43, 32'h0, 32'h00003344, 0));
    vt.push_back(mk(1, 1, 0, 32'h41, 32'h00005566, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h40, 32'h0, 32'h55663344, 0));
`endif

    foreach (vt[i]) begin
      model_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, erd, eer);
      do_req(1, vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: response held 5 cycles while a second request waits on req_valid.
    model_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, erd, eer);
    req_write[1] = 1'b0; req_size[1] = 2'd2; req_signed[1] = 1'b0;
    req_addr[1] = 32'h20; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_write[1] = 1'b1; req_addr[1] = 32'h50; req_wdata[1] = 32'h0BADF00D;
    n = 0;
    while (resp_valid[1] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("bp resp_valid", {31'h0, resp_valid[1]}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d resp_valid", c), {31'h0, resp_valid[1]}, 32'h1);
      check($sformatf("bp%0d rdata", c), resp_rdata[1], erd);
      check($sformatf("bp%0d err", c), {31'h0, resp_err[1]}, 32'h0);
      check($sformatf("bp%0d req_ready", c), {31'h0, req_ready[1]}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    check("bp post-hs resp_valid", {31'h0, resp_valid[1]}, 32'h0);
    check("bp post-hs req_ready", {31'h0, req_ready[1]}, 32'h1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("bp second accepted", {31'h0, req_ready[1]}, 32'h0);
    n = 0;
    while (resp_valid[1] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("bp store err", {31'h0, resp_err[1]}, 32'h0);
    check("bp store rdata", resp_rdata[1], 32'h0);
    model_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h0BADF00D, erd, eer);
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, rd, er, lat);
    check("bp store readback", rd, 32'h0BADF00D);

    // Zero wait states.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D, rd, er, lat);
    check("wc0 store latency", 32'(lat), 32'd1);
    check("wc0 store err", {31'h0, er}, 32'h0);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er, lat);
    check("wc0 load latency", 32'(lat), 32'd1);
    check("wc0 load rdata", rd, 32'hCAFEF00D);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h8, 32'h0, rd, er, lat);
    check("wc0 sbyte rdata", rd, 32'hFFFFFFCA);
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0, rd, er, lat);
    check("wc0 range err", {31'h0, er}, 32'h1);

    // Reset while a store sits in WAIT: the store must not land.
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, erd, eer);
    req_write[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h40;
    req_wdata[1] = 32'h99999999; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("rstwait in wait", {31'h0, req_ready[1]}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("rstwait req_ready", {31'h0, req_ready[1]}, 32'h1);
    check("rstwait resp_valid", {31'h0, resp_valid[1]}, 32'h0);
    check("rstwait rdata", resp_rdata[1], 32'h0);
    check("rstwait err", {31'h0, resp_err[1]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("rstwait mem unchanged", rd, erd);

    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1030));
      wd = $urandom;
      model_req(w, sz, sg, a, wd, erd, eer);
      do_req(1, w, sz, sg, a, wd, rd, er, lat);
      check($sformatf("rand%0d rdata", i), rd, erd);
      check($sformatf("rand%0d err", i), {31'h0, er}, {31'h0, eer});
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressable, big-endian data memory with a valid/ready request/response handshake.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Programmable wait-state latency; range and alignment checking.
- Sits behind the MEM stage of the ARM pipeline, replacing the fixed word-only, combinational-read memory; the pipeline stalls on req_ready/resp_valid.

Parameters:
- ADDR_W, 32, request address width in bits.
- MEM_BYTES, 1024, storage size in bytes; must be a multiple of 4.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; 0 is legal.
- DATA_W, 32, data width; fixed at 32 in this generation, all size encodings assume it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error).
- req_signed  in  1  load sign-extends when 1; ignored for stores and words.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  request was out of range, misaligned (see feature) or reserved size.

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE, wait counter 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, capture write, size, signed, addr and wdata.
  - Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES=0.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter=0, go to RESP.
- Access timing:
  - The memory access occurs on the edge that enters RESP.
  - Stores write bytes on that edge; loads register resp_rdata on that edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stable.
  - Hold until resp_ready=1; on that edge go to IDLE and clear resp_valid.
  - req_ready=0 throughout RESP; a new request is not accepted in the same cycle as the handshake.
- Latency and throughput:
  - Accept edge to resp_valid high is WAIT_CYCLES+1 cycles.
  - Minimum throughput is one request per WAIT_CYCLES+2 cycles.
- Byte order is big-endian; mem[a] is the most significant byte:
  - Word = {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
  - Halfword = {mem[a],mem[a+1]}.
  - Byte = mem[a].
- Range check:
  - If a + nbytes > MEM_BYTES (computed at ADDR_W+1 bits, no wrap), set resp_err=1.
  - On error: no bytes written, resp_rdata=0.
- Reserved size 11 gives resp_err=1 and no access.
- Reset mid-operation aborts the request; a store that has not reached the RESP-entry edge is not performed.
- req_* inputs are sampled only on the accept edge; changes during WAIT/RESP are ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: halfword with a[0]=1, or word with a[1:0]!=0, gives resp_err=1, no write, rdata=0.
- Undefined: low address bits are forced to alignment (a[0] cleared for halfword, a[1:0] cleared for word) and the access proceeds; misalignment alone never sets resp_err.

Decomposition:
- Shared package holds:
  - Size encodings SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD.
  - FSM state typedef.
  - DATA_W default.
- Natural sub-module: mem_byte_array, a plain MEM_BYTES x 8 storage with a 4-lane byte-enabled write port and a 4-byte read port.
- data_mem_ctrl holds the FSM, wait counter, range/align checks, lane steering and extension.

Test Plan:
- Word store then load, WAIT_CYCLES=1: store 0x12345678 at 0x10, then load word at 0x10 -> rdata 0x12345678; mem[0x10]=0x12 and mem[0x13]=0x78; resp_valid exactly 2 cycles after each accept.
- Byte and halfword loads over word 0x80FF7F01 at 0x20:
  - Signed byte at 0x20 -> 0xFFFFFF80.
  - Unsigned byte at 0x21 -> 0x000000FF.
  - Signed half at 0x22 -> 0x00007F01.
  - Signed half at 0x20 -> 0xFFFF80FF.
- Partial stores: byte store 0xAB at 0x21 over 0x80FF7F01 -> word reads 0x80AB7F01; halfword store 0xCDEF at 0x22 -> word reads 0x80ABCDEF.
- Range check, MEM_BYTES=1024:
  - Word load at 0x3FC -> ok.
  - Word store at 0x3FE -> resp_err=1; re-reading 0x3FC shows no change.
  - Byte load at 0x400 -> resp_err=1, rdata 0.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err held, req_ready=0; a new req_valid is ignored until one cycle after the handshake. Repeat with WAIT_CYCLES=0 -> response 1 cycle after accept.
- Reset and alignment:
  - Assert rst during WAIT of a store to 0x40 -> outputs return to reset values, mem[0x40..0x43] unchanged.
  - Word load at 0x42: with MEM_ALIGN_CHECK_EN -> resp_err=1; without it -> returns the word at 0x40.
